// File: rtl/jk_reg_bank.sv
// WIDTH-bit register built from JK flip-flop behaviour: per-bit JK, up/down counter or
// left shifter, with parallel load, terminal-count flag and a registered change pulse.
module jk_reg_bank #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             chg
);

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DN    = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    mode_e            modeSel;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             chg_q;
    logic [WIDTH-1:0] lowOnes;
    logic [WIDTH-1:0] lowZeros;

    assign modeSel = mode_e'(mode);

    function automatic logic jk(input logic j, input logic k, input logic q);
        logic r;
        case ({j, k})
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

    // Ripple-style toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        lowOnes  = '0;
        lowZeros = '0;
        lowOnes[0]  = 1'b1;
        lowZeros[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            lowOnes[i]  = lowOnes[i-1]  &  q_q[i-1];
            lowZeros[i] = lowZeros[i-1] & ~q_q[i-1];
        end
    end

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (en) begin
            case (modeSel)
                MODE_JK: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        q_d[i] = jk(J[i], K[i], q_q[i]);
                    end
                end
                MODE_UP:    q_d = q_q ^ lowOnes;
                MODE_DN:    q_d = q_q ^ lowZeros;
                MODE_SHIFT: q_d = {q_q[WIDTH-2:0], jk(J[0], K[0], q_q[0])};
                default:    q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= RST_VAL;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= (q_d != q_q);
        end
    end

    always_comb begin
        tc = 1'b0;
        case (modeSel)
            MODE_UP: tc = &q_q;
            MODE_DN: tc = ~|q_q;
            default: tc = 1'b0;
        endcase
    end

    assign Q   = q_q;
    assign Qn  = ~q_q;
    assign chg = chg_q;

endmodule
